// File: rtl/gol_pkg.sv
// Shared constants, types and the species palette for the Game-of-Life
// census and HUD overlay path.
package gol_pkg;

  localparam int NUM_SPECIES = 7;
  localparam int CELL_W      = 4;
  localparam int CNT_W       = 17;
  localparam int X_W         = 11;
  localparam int Y_W         = 10;

  // 720p active area
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;

  localparam logic [CNT_W-1:0] CNT_SAT = 17'h10000;

  typedef logic [23:0] rgb_t;
  typedef logic [2:0]  species_t;

  // Same colours svo_hdmi uses to paint the cells themselves.
  function automatic rgb_t palette(input species_t s);
    case (s)
      3'd1:    palette = 24'hFF4040;
      3'd2:    palette = 24'h40FF40;
      3'd3:    palette = 24'h4040FF;
      3'd4:    palette = 24'hFFFF40;
      3'd5:    palette = 24'hFF40FF;
      3'd6:    palette = 24'h40FFFF;
      3'd7:    palette = 24'hFFFFFF;
      default: palette = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/census_counter.sv
// One species accumulator: saturating count, copied to a snapshot and
// restarted at the frame boundary.
module census_counter
  import gol_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_snap,
  output logic [CNT_W-1:0] o_acc,
  output logic [CNT_W-1:0] o_snap
);

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_snap;

  // A hit on the boundary cycle belongs to the new frame, so it seeds the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else if (i_snap) begin
      r_snap <= r_acc;
      r_acc  <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_acc != CNT_SAT)) begin
      r_acc <= r_acc + CNT_W'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_snap = r_snap;

endmodule

// File: rtl/gol_census_hud.sv
// Per-frame species census with a 7-bar histogram drawn over the next frame;
// every video signal leaves exactly two pixel clocks after it arrives.
module gol_census_hud
  import gol_pkg::*;
#(
  parameter int BAR_X0  = 16,
  parameter int BAR_Y0  = 16,
  parameter int BAR_H   = 8,
  parameter int SHIFT   = 8,
  parameter int BAR_MAX = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hud_en,
  input  logic [7:0]        i_r,
  input  logic [7:0]        i_g,
  input  logic [7:0]        i_b,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic              cell_valid,
  input  logic [CELL_W-1:0] cell_state,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic              census_valid,
  output logic [CNT_W-1:0]  live_total
);

  localparam int LEN_W = $clog2(BAR_MAX + 1);
  localparam int SUM_W = CNT_W + 3;

  // Stage-1 registers double as the previous-cycle samples for edge detection.
  logic             r1_hs, r1_vs, r1_de;
  rgb_t             r1_rgb;
  species_t         r1_hit;
  logic             r2_hs, r2_vs, r2_de;
  rgb_t             r2_rgb;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_hud_on;
  logic             r_census_valid;
  logic [CNT_W-1:0] r_live_total;
  logic [LEN_W-1:0] r_len [1:NUM_SPECIES];

  logic             w_vs_rise;
  logic             w_de_fall;
  logic [CNT_W-1:0] w_acc  [1:NUM_SPECIES];
  logic [CNT_W-1:0] w_snap [1:NUM_SPECIES];
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_total;
  species_t         w_hit;
  logic             w_in_active;
  logic             w_hit_en;

  assign w_vs_rise = i_vs & ~r1_vs;
  assign w_de_fall = r1_de & ~i_de;

  // cell_valid is a qualifier-only pulse (no ready); census_valid is a
  // one-cycle strobe, and live_total is stable from that strobe until the next.
  for (genvar g = 1; g <= NUM_SPECIES; g++) begin : g_cnt
    census_counter u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (cell_valid && (cell_state == CELL_W'(g))),
      .i_snap (w_vs_rise),
      .o_acc  (w_acc[g]),
      .o_snap (w_snap[g])
    );
  end

  // Seven saturated counts can exceed the output width; pin at all-ones.
  always_comb begin
    w_sum = '0;
    for (int s = 1; s <= NUM_SPECIES; s++) begin
      w_sum = w_sum + SUM_W'(w_acc[s]);
    end
    w_total = (w_sum > SUM_W'(2**CNT_W - 1)) ? '1 : w_sum[CNT_W-1:0];
  end

  function automatic logic [LEN_W-1:0] bar_len(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] sh;
    sh = c >> SHIFT;
    bar_len = (sh > CNT_W'(BAR_MAX)) ? LEN_W'(BAR_MAX) : sh[LEN_W-1:0];
  endfunction

  always_comb begin
    w_hit       = '0;
    w_in_active = (r_x < X_W'(H_ACTIVE)) && (r_y < Y_W'(V_ACTIVE));
    for (int s = 1; s <= NUM_SPECIES; s++) begin
      if ((r_y >= Y_W'(BAR_Y0 + (s - 1) * (BAR_H + 2))) &&
          (r_y <  Y_W'(BAR_Y0 + (s - 1) * (BAR_H + 2) + BAR_H)) &&
          ({1'b0, r_x} >= 12'(BAR_X0)) &&
          ({1'b0, r_x} <  12'(BAR_X0) + 12'(r_len[s]))) begin
        w_hit = 3'(s);
      end
    end
    w_hit_en = r_hud_on && i_de && w_in_active && (w_hit != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_de_fall) begin
        r_x <= '0;
      end else if (i_de) begin
        r_x <= r_x + X_W'(1);
      end
      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall) begin
        r_y <= r_y + Y_W'(1);
      end
    end
  end

  // Snapshot side: totals and hud_on at the boundary, bar lengths one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hud_on       <= 1'b0;
      r_census_valid <= 1'b0;
      r_live_total   <= '0;
      for (int s = 1; s <= NUM_SPECIES; s++) begin
        r_len[s] <= '0;
      end
    end else begin
      r_census_valid <= w_vs_rise;
      if (w_vs_rise) begin
        r_live_total <= w_total;
        r_hud_on     <= hud_en;
      end
      if (r_census_valid) begin
        for (int s = 1; s <= NUM_SPECIES; s++) begin
          r_len[s] <= bar_len(w_snap[s]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_hs  <= 1'b0;
      r1_vs  <= 1'b0;
      r1_de  <= 1'b0;
      r1_rgb <= '0;
      r1_hit <= '0;
      r2_hs  <= 1'b0;
      r2_vs  <= 1'b0;
      r2_de  <= 1'b0;
      r2_rgb <= '0;
    end else begin
      r1_hs  <= i_hs;
      r1_vs  <= i_vs;
      r1_de  <= i_de;
      r1_rgb <= {i_r, i_g, i_b};
      r1_hit <= w_hit_en ? w_hit : '0;
      r2_hs  <= r1_hs;
      r2_vs  <= r1_vs;
      r2_de  <= r1_de;
      r2_rgb <= (r1_hit != '0) ? palette(r1_hit) : r1_rgb;
    end
  end

  assign {o_r, o_g, o_b} = r2_rgb;
  assign o_hs            = r2_hs;
  assign o_vs            = r2_vs;
  assign o_de            = r2_de;
  assign census_valid    = r_census_valid;
  assign live_total      = r_live_total;

endmodule

// File: tb/tb_gol_census_hud.sv
// Directed bench for gol_census_hud: video and census results are queued at
// stimulus time and popped by a monitor when the DUT presents them.
module tb_gol_census_hud;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hud_en;
  logic [7:0]  i_r, i_g, i_b;
  logic        i_hs, i_vs, i_de;
  logic        cell_valid;
  logic [3:0]  cell_state;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hs, o_vs, o_de;
  logic        census_valid;
  logic [16:0] live_total;

  always #5 clk = ~clk;

  gol_census_hud dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hud_en       (hud_en),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .i_hs         (i_hs),
    .i_vs         (i_vs),
    .i_de         (i_de),
    .cell_valid   (cell_valid),
    .cell_state   (cell_state),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_hs         (o_hs),
    .o_vs         (o_vs),
    .o_de         (o_de),
    .census_valid (census_valid),
    .live_total   (live_total)
  );

  // ---------------- scoreboard state ----------------
  logic [26:0] exp_q[$];
  logic [16:0] cen_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_len [1:7];
  logic        tb_tag;
  logic        tag_d1, tag_d2;
  logic [23:0] tb_pal [0:7] = '{24'h000000, 24'hFF4040, 24'h40FF40, 24'h4040FF,
                                24'hFFFF40, 24'hFF40FF, 24'h40FFFF, 24'hFFFFFF};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {o_r, o_g, o_b, o_hs, o_vs, o_de, census_valid, live_total}, 64'd0);
  endtask

  // Marks which driven cycles are due at the output two clocks later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_d1 <= 1'b0;
      tag_d2 <= 1'b0;
    end else begin
      tag_d1 <= tb_tag;
      tag_d2 <= tag_d1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (tag_d2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL video_underflow actual=output_present expected=none t=%0t", $time);
      end else begin
        check("video", {o_de, o_hs, o_vs, o_r, o_g, o_b}, exp_q.pop_front());
      end
    end
    if (census_valid) begin
      if (cen_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL census_extra actual=pulse expected=none t=%0t", $time);
      end else begin
        check("live_total", live_total, cen_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic vs, input logic hs, input logic de,
                     input logic [23:0] rgb, input logic [23:0] expv);
    i_vs = vs;
    i_hs = hs;
    i_de = de;
    {i_r, i_g, i_b} = rgb;
    tb_tag = 1'b1;
    exp_q.push_back({de, hs, vs, expv});
  endtask

  function automatic logic [23:0] exp_pix(input logic hud, input int l, input int c,
                                          input logic [23:0] rgb);
    int lo;
    exp_pix = rgb;
    if (hud) begin
      for (int s = 1; s <= 7; s++) begin
        lo = 16 + (s - 1) * 10;
        if (l >= lo && l < lo + 8 && c >= 16 && c < 16 + exp_len[s]) exp_pix = tb_pal[s];
      end
    end
  endfunction

  task automatic cells(input logic [3:0] st, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cell_valid = 1'b1;
      cell_state = st;
    end
    @(negedge clk);
    cell_valid = 1'b0;
  endtask

  // Vsync rising edge (census expected = total), then nlines active lines.
  task automatic run_frame(input logic [16:0] total, input logic hud, input int nlines,
                           input int nw, input int ww, input int wlo, input int whi,
                           input logic [3:0] edge_st, input int rst_line);
    logic [23:0] pix;
    int          w;
    @(negedge clk);
    hud_en = hud;
    cen_q.push_back(total);
    if (edge_st != 4'd0) begin
      cell_valid = 1'b1;
      cell_state = edge_st;
    end
    put(1'b1, 1'b0, 1'b0, 24'h0F0F0F, 24'h0F0F0F);
    @(negedge clk);
    if (edge_st != 4'd0) cell_valid = 1'b0;
    put(1'b1, 1'b0, 1'b0, 24'h0F0F0F, 24'h0F0F0F);
    repeat (2) begin
      @(negedge clk);
      put(1'b0, 1'b0, 1'b0, 24'h0F0F0F, 24'h0F0F0F);
    end
    for (int l = 0; l < nlines; l++) begin
      if (l == rst_line) begin
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        tb_tag = 1'b0;
        exp_q.delete();
        #1;
        check_zero("reset_mid_out");
        repeat (2) begin
          @(negedge clk);
          #1;
          check_zero("reset_mid_out");
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (l == 1) hud_en = ~hud;
      w = (l >= wlo && l <= whi) ? ww : nw;
      for (int c = 0; c < w; c++) begin
        @(negedge clk);
        pix = {8'(c), 8'(l), 8'hA5};
        put(1'b0, 1'b0, 1'b1, pix, exp_pix(hud, l, c, pix));
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        put(1'b0, (k == 0), 1'b0, 24'h3C5A69, 24'h3C5A69);
      end
    end
    @(negedge clk);
    tb_tag = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    hud_en     = 1'b0;
    {i_r, i_g, i_b} = 24'h0;
    i_hs       = 1'b0;
    i_vs       = 1'b0;
    i_de       = 1'b0;
    cell_valid = 1'b0;
    cell_state = 4'd0;
    tb_tag     = 1'b0;
    for (int s = 1; s <= 7; s++) exp_len[s] = 0;

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_out");
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through with the overlay off.
    repeat (3) run_frame(17'd0, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);

    // 256 x species 1 and 512 x species 3.
    fork
      run_frame(17'd0, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);
      begin
        cells(4'd1, 256);
        cells(4'd3, 512);
      end
    join
    exp_len[1] = 1;
    exp_len[3] = 2;
    fork
      run_frame(17'd768, 1'b1, 45, 24, 24, 0, -1, 4'd0, -1);
      begin
        cells(4'd0, 3);
        cells(4'd8, 3);
        cells(4'd15, 3);
      end
    join
    exp_len[1] = 0;
    exp_len[3] = 0;

    // Ignored states only -> empty histogram; meanwhile 65537 x species 7.
    fork
      run_frame(17'd0, 1'b1, 45, 24, 24, 0, -1, 4'd0, -1);
      cells(4'd7, 65537);
    join
    exp_len[7] = 256;
    run_frame(17'd65536, 1'b1, 86, 2, 280, 74, 84, 4'd0, -1);
    exp_len[7] = 0;

    // A cell on the boundary cycle belongs to the next snapshot.
    fork
      run_frame(17'd0, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);
      cells(4'd2, 2);
    join
    run_frame(17'd2, 1'b0, 4, 16, 16, 0, -1, 4'd4, -1);
    run_frame(17'd1, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);

    // Mid-frame reset: pre-reset counts are lost.
    fork
      run_frame(17'd0, 1'b0, 5, 16, 16, 0, -1, 4'd0, 2);
      cells(4'd6, 5);
    join
    cells(4'd5, 3);
    run_frame(17'd3, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);
    run_frame(17'd0, 1'b0, 4, 16, 16, 0, -1, 4'd0, -1);

    repeat (5) @(negedge clk);
    check("video_q_drain", 64'(exp_q.size()), 64'd0);
    check("census_q_drain", 64'(cen_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gol_census_hud.md
# gol_census_hud

Per-frame census and overlay stage between `svo_hdmi` and `DVI_TX_Top`. It counts live cells of each of the 7 species from the cell-read stream during one frame. At the frame boundary it latches the totals. During the next frame it draws a 7-bar histogram over the 720p RGB stream, with a fixed 2-cycle delay on all video signals.

## Interface
- `BAR_X0`, default 16: first pixel column of the bars.
- `BAR_Y0`, default 16: first pixel row of bar 1.
- `BAR_H`, default 8: rows per bar, with 2 blank rows between bars.
- `SHIFT`, default 8: right-shift applied to a count to get bar length in pixels. 65536 >> 8 = 256 px.
- `BAR_MAX`, default 256: bar length clamp, in pixels.
- `clk`  in  1  pixel clock (74.25 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `hud_en`  in  1  overlay enable, sampled at frame start.
- `i_r`, `i_g`, `i_b`  in  8 each  RGB from `svo_hdmi`.
- `i_hs`, `i_vs`, `i_de`  in  1 each  syncs from `svo_hdmi`; `i_vs` is active-high.
- `cell_valid`  in  1  one-cycle pulse, at most once per distinct cell per frame.
- `cell_state`  in  4  state of that cell: 0 dead, 1–7 species, 8–15 ignored.
- `o_r`, `o_g`, `o_b`  out  8 each  overlaid RGB.
- `o_hs`, `o_vs`, `o_de`  out  1 each  delayed syncs.
- `census_valid`  out  1  one-cycle pulse when a new snapshot is latched.
- `live_total`  out  17  sum of the latched species counts.

## Operation
- Accumulators: seven 17-bit counters `acc[1..7]`.
  - `cell_valid` with `cell_state` = s, s in 1..7, increments `acc[s]`.
  - Counters saturate at 65536.
  - States 0 and 8–15 are not counted.
- Frame boundary: a rising edge of `i_vs` (registered edge detect).
  - Copy `acc` to `snap[1..7]` and clear `acc`.
  - Sample `hud_en` into `hud_on`.
  - Pulse `census_valid` and update `live_total`.
  - A `cell_valid` in the same cycle as the edge counts into the cleared accumulator, giving `acc[s]` = 1.
- Bar lengths: `len[s]` = min(`snap[s]` >> `SHIFT`, `BAR_MAX`), computed once per snapshot and registered.
- Pixel position, tracked by internal counters:
  - `x` (11 bit) increments while `i_de` is high and clears on the falling edge of `i_de`.
  - `y` (10 bit) increments on each `i_de` falling edge and clears on the rising edge of `i_vs`.
- Bar s occupies rows `BAR_Y0 + (s-1)*(BAR_H+2)` to that value + `BAR_H` − 1, and columns `BAR_X0` to `BAR_X0 + len[s]` − 1.
- Overlay rule: inside bar s, with `hud_on` = 1 and `i_de` = 1, output `PALETTE[s]`. Otherwise pass the input through unchanged.
- `len[s]` = 0 draws nothing for that bar.

## Timing
- Stage 1 registers the inputs plus `x`, `y` and the bar-hit decode.
- Stage 2 registers the RGB mux output.
- `o_hs`, `o_vs`, `o_de` are the inputs delayed by exactly 2 cycles, with no dependence on any other signal.
- `census_valid` asserts 1 cycle after the `i_vs` rising edge. `live_total` is valid in that same cycle and holds until the next snapshot.
- Reset values:
  - All outputs 0.
  - `acc`, `snap`, `len` all 0.
  - `hud_on` 0.
  - `x`, `y` 0.
  - Edge detector primed low.
- Reset mid-frame: outputs are 0 immediately. The first `i_vs` edge after release produces a snapshot of the partial frame, which is legal.
- `hud_en` toggling mid-frame has no effect until the next frame boundary.

## Structure
- Package `gol_pkg` holds:
  - `NUM_SPECIES` = 7.
  - `CELL_W` = 4.
  - `CNT_W` = 17.
  - `PALETTE[1..7]`, 24-bit RGB per species, shared with `svo_hdmi`.
  - The 720p timing constants: 1280 active columns, 720 active rows.
- One sub-module, `census_counter`: one saturating accumulator with snapshot/clear, instantiated 7 times.

## Test plan
- Reset, then 3 frames of pass-through video with `hud_en` = 0 → output equals input delayed 2 cycles bit-exact, and no pixel is altered.
- One frame with 256 `cell_valid` pulses of state 1 and 512 of state 3, then the `i_vs` edge:
  - `census_valid` pulses once; `live_total` = 768.
  - With `hud_en` = 1, the next frame shows bar 1 of 1 px, bar 3 of 2 px, and nothing else.
- 65537 pulses of state 7 in one frame → `snap[7]` = 65536 and bar 7 clamps to 256 px at columns 16..271.
- `cell_valid` with state 4 on the same cycle as the `i_vs` rising edge → that cell appears in the next snapshot (count 1), not the current one.
- Pulses with `cell_state` of 0, 8 and 15 → all counts stay 0 and `live_total` = 0.
- `rst_n` asserted for 3 cycles mid-frame → all outputs read 0 during reset. After release, the first snapshot holds only the post-reset counts, and the video delay is 2 cycles again.
